// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared widths, state encoding and small helpers for the accumulator
// normaliser slice of the MAC datapath.
//   ops format : {sgn, exp[EXP_W-1:0], man[MAN_W-1:0]} (16 bits, hidden one)
//   aligned    : ALIGN_W-bit two's complement, binary point below bit 15
//   sum        : SUM_W-bit two's complement sum of two aligned mantissas
// -----------------------------------------------------------------------------
package acc_pkg;

    localparam int EXP_W   = 4;
    localparam int MAN_W   = 11;
    localparam int ALIGN_W = 17;
    localparam int SUM_W   = 18;
    localparam int OPS_W   = 1 + EXP_W + MAN_W;
    localparam int LZC_W   = 5;

    // Largest finite magnitude in ops format (exp and mantissa all ones).
    localparam logic [OPS_W-2:0] SAT_MAG = 15'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01,
        ST_NORM = 2'b10,
        ST_OUT  = 2'b11
    } acc_state_e;

    // Sign-extend an aligned mantissa to the sum width.
    function automatic logic [SUM_W-1:0] sext_align(input logic [ALIGN_W-1:0] v);
        return {v[ALIGN_W-1], v};
    endfunction

    // Assemble an ops-format word.
    function automatic logic [OPS_W-1:0] pack_ops(input logic             sgn,
                                                  input logic [EXP_W-1:0] exp,
                                                  input logic [MAN_W-1:0] man);
        return {sgn, exp, man};
    endfunction

endpackage

// File: rtl/acc_lzc.sv
// -----------------------------------------------------------------------------
// acc_lzc
// Combinational leading-zero counter over the SUM_W-bit magnitude.
//   value    in   SUM_W  magnitude to inspect
//   lz_count out  LZC_W  number of zeros above the leading one (SUM_W if zero)
// -----------------------------------------------------------------------------
module acc_lzc
    import acc_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [LZC_W-1:0] lz_count
);

    // Scan upward so the highest set bit is the last one to set the count.
    always_comb begin
        lz_count = LZC_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            lz_count = value[i] ? LZC_W'(SUM_W - 1 - i) : lz_count;
        end
    end

endmodule

// File: rtl/acc_normalizer.sv
// -----------------------------------------------------------------------------
// acc_normalizer
// Adds two aligned mantissas, normalises and rounds (nearest-even) the sum to
// ops format and keeps it in the accumulator fed back to the aligner. The op
// flagged in_last is presented on a valid/ready output together with a sticky
// saturation flag and the number of ops in the run.
//   clk, rst_n      clock, synchronous active-low reset
//   clear           synchronous clear of accumulator/count/sat, aborts op
//   in_valid/ready  aligned-operand handshake; in_last ends the run
//   align_sgn       [1] effective subtract, [0] sign of larger-exp operand
//   align_exp       common exponent
//   align_man0/1    aligned two's-complement mantissas
//   acc_ops         accumulator value (ops format)
//   out_valid/ready final-result handshake
//   out_data        final result (ops format)
//   out_sat         exponent overflow saturated during the run
//   out_count       ops accepted in the run (saturating)
// -----------------------------------------------------------------------------
module acc_normalizer
    import acc_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [1:0]         align_sgn,
    input  logic [EXP_W-1:0]   align_exp,
    input  logic [ALIGN_W-1:0] align_man0,
    input  logic [ALIGN_W-1:0] align_man1,
    output logic [OPS_W-1:0]   acc_ops,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPS_W-1:0]   out_data,
    output logic               out_sat,
    output logic [COUNT_W-1:0] out_count
);

    acc_state_e          state_r;
    logic                sgn_r;
    logic [EXP_W-1:0]    exp_r;
    logic [ALIGN_W-1:0]  man0_r;
    logic [ALIGN_W-1:0]  man1_r;
    logic                last_r;
    logic [SUM_W-1:0]    mag_r;
    logic                res_sgn_r;
    logic [OPS_W-1:0]    acc_ops_r;
    logic                out_valid_r;
    logic [OPS_W-1:0]    out_data_r;
    logic                sat_r;
    logic [COUNT_W-1:0]  count_r;

    logic [SUM_W-1:0]    sum_s;
    logic                sum_neg_s;
    logic [SUM_W-1:0]    mag_s;
    logic [LZC_W-1:0]    lz_s;
    logic [SUM_W-1:0]    norm_s;
    logic                sticky_s;
    logic                round_up_s;
    logic [MAN_W:0]      man_rnd_s;
    logic                carry_s;
    logic [6:0]          exp_new_s;
    logic                ovf_s;
    logic                unf_s;
    logic                mag_zero_s;
    logic                sat_set_s;
    logic [OPS_W-1:0]    res_s;
    logic [COUNT_W-1:0]  count_inc_s;

    // The effective-subtract flag is already folded into the two's-complement
    // mantissas by the aligner, so only the larger-operand sign is needed.
    logic unused_sub_s;
    assign unused_sub_s = align_sgn[1];

    assign in_ready  = (state_r == ST_IDLE) && !clear;
    assign acc_ops   = acc_ops_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = sat_r;
    assign out_count = count_r;

    // Saturating increment of the op counter.
    always_comb begin
        if (count_r == {COUNT_W{1'b1}}) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ADD stage: signed sum of the captured mantissas and its magnitude.
    always_comb begin
        sum_s     = sext_align(man0_r) + sext_align(man1_r);
        sum_neg_s = sum_s[SUM_W-1];
        if (sum_neg_s) begin
            mag_s = -sum_s;
        end else begin
            mag_s = sum_s;
        end
    end

    acc_lzc u_lzc (
        .value    (mag_r),
        .lz_count (lz_s)
    );

    // NORM stage: bring the leading one to bit 15, round, rebuild exponent.
    always_comb begin
        // lz 0/1 means the leading one sits above the hidden-bit position and
        // the shifted-out bits feed the sticky; otherwise shift left.
        if (lz_s == 5'd0) begin
            norm_s   = mag_r >> 2;
            sticky_s = |mag_r[1:0];
        end else if (lz_s == 5'd1) begin
            norm_s   = mag_r >> 1;
            sticky_s = mag_r[0];
        end else begin
            norm_s   = mag_r << (lz_s - 5'd2);
            sticky_s = 1'b0;
        end

        // Mantissa is bits[14:4]; bit 3 is the guard, the rest is sticky.
        round_up_s = norm_s[3] & (norm_s[4] | (|norm_s[2:0]) | sticky_s);
        man_rnd_s  = {1'b0, norm_s[14:4]} + {{MAN_W{1'b0}}, round_up_s};
        // A carry out leaves the low mantissa bits at zero: 1.111.. -> 10.000..
        carry_s    = man_rnd_s[MAN_W];

        // Exponent adjust is exp + (2 - lz) + carry, held as 7-bit signed.
        exp_new_s  = {3'b000, exp_r} + 7'd2 - {2'b00, lz_s} + {6'b000000, carry_s};
        unf_s      = exp_new_s[6];
        ovf_s      = !exp_new_s[6] && (exp_new_s[5:4] != 2'b00);
        mag_zero_s = (mag_r == {SUM_W{1'b0}});
        sat_set_s  = !mag_zero_s && ovf_s;

        if (mag_zero_s) begin
            res_s = {OPS_W{1'b0}};
        end else if (ovf_s) begin
            res_s = {res_sgn_r, SAT_MAG};
        end else if (unf_s) begin
            res_s = {OPS_W{1'b0}};
        end else begin
            res_s = pack_ops(res_sgn_r, exp_new_s[EXP_W-1:0], man_rnd_s[MAN_W-1:0]);
        end
    end

    // Control FSM together with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sgn_r       <= 1'b0;
            exp_r       <= {EXP_W{1'b0}};
            man0_r      <= {ALIGN_W{1'b0}};
            man1_r      <= {ALIGN_W{1'b0}};
            last_r      <= 1'b0;
            mag_r       <= {SUM_W{1'b0}};
            res_sgn_r   <= 1'b0;
            acc_ops_r   <= {OPS_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {OPS_W{1'b0}};
            sat_r       <= 1'b0;
            count_r     <= {COUNT_W{1'b0}};
        end else if (clear) begin
            state_r     <= ST_IDLE;
            acc_ops_r   <= {OPS_W{1'b0}};
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
            count_r     <= {COUNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sgn_r   <= align_sgn[0];
                        exp_r   <= align_exp;
                        man0_r  <= align_man0;
                        man1_r  <= align_man1;
                        last_r  <= in_last;
                        count_r <= count_inc_s;
                        state_r <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    mag_r     <= mag_s;
                    // A negative sum means the smaller operand won.
                    res_sgn_r <= sum_neg_s ? ~sgn_r : sgn_r;
                    state_r   <= ST_NORM;
                end
                ST_NORM: begin
                    acc_ops_r <= res_s;
                    if (sat_set_s) begin
                        sat_r <= 1'b1;
                    end
                    if (last_r) begin
                        out_data_r  <= res_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        acc_ops_r   <= {OPS_W{1'b0}};
                        count_r     <= {COUNT_W{1'b0}};
                        sat_r       <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_normalizer.sv
// -----------------------------------------------------------------------------
// tb_acc_normalizer
// Directed vectors with hand-computed expected results for acc_normalizer.
// -----------------------------------------------------------------------------
module tb_acc_normalizer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  align_sgn;
    logic [3:0]  align_exp;
    logic [16:0] align_man0;
    logic [16:0] align_man1;
    logic [15:0] acc_ops;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic [7:0]  out_count;

    int n_tests;
    int n_fail;

    acc_normalizer #(.COUNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .align_sgn  (align_sgn),
        .align_exp  (align_exp),
        .align_man0 (align_man0),
        .align_man1 (align_man1),
        .acc_ops    (acc_ops),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_count  (out_count)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Issue one op at a negedge and wait until its result is in acc_ops.
    task automatic send_op(input logic [16:0] m0, input logic [16:0] m1,
                           input logic [1:0] sg, input logic [3:0] ex, input logic last);
        @(negedge clk);
        check_val("accept_ready", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        align_man0 = m0;
        align_man1 = m1;
        align_sgn  = sg;
        align_exp  = ex;
        in_last    = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_val("busy_add", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_val("busy_norm", 32'(in_ready), 32'd0);
        @(negedge clk);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        align_sgn  = 2'b00;
        align_exp  = 4'd0;
        align_man0 = 17'h00000;
        align_man1 = 17'h00000;
        out_ready  = 1'b0;

        // Reset: one edge with rst_n low.
        @(negedge clk);
        check_val("rst_acc", 32'(acc_ops), 32'h0000);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_count", 32'(out_count), 32'd0);
        check_val("rst_data", 32'(out_data), 32'h0000);
        check_val("rst_sat", 32'(out_sat), 32'd0);
        rst_n = 1'b1;

        // Carry into bit 16: 1.0 + 1.0 at exp 3 -> 1.0 * 2^4.
        send_op(17'h08000, 17'h08000, 2'b00, 4'd3, 1'b0);
        check_val("carry_acc", 32'(acc_ops), 32'h2000);
        check_val("carry_idle", 32'(in_ready), 32'd1);

        // Exact cancellation -> positive zero.
        send_op(17'h08000, 17'h18000, 2'b10, 4'd6, 1'b0);
        check_val("cancel_acc", 32'(acc_ops), 32'h0000);

        // RNE tie rounds up to even, then tie stays at even.
        send_op(17'h08018, 17'h00000, 2'b00, 4'd5, 1'b0);
        check_val("rne_up", 32'(acc_ops), 32'h2802);
        send_op(17'h08008, 17'h00000, 2'b00, 4'd5, 1'b0);
        check_val("rne_even", 32'(acc_ops), 32'h2800);

        // Negative sum: -1.0 + -0.5 -> sign flips, 1.1b * 2^7.
        send_op(17'h18000, 17'h1C000, 2'b00, 4'd7, 1'b0);
        check_val("neg_acc", 32'(acc_ops), 32'hBC00);

        // Rounding carry out of the mantissa: 0x1FFFE >> 1 rounds to 2.0.
        send_op(17'h0FFFF, 17'h0FFFF, 2'b00, 4'd4, 1'b0);
        check_val("rnd_carry", 32'(acc_ops), 32'h3000);

        // Sticky from the right-shifted bit breaks the tie upward.
        send_op(17'h0C011, 17'h04000, 2'b00, 4'd1, 1'b0);
        check_val("sticky_acc", 32'(acc_ops), 32'h1001);

        // Sum of -2^16 twice: right shift by 2, sign flips.
        send_op(17'h10000, 17'h10000, 2'b00, 4'd2, 1'b0);
        check_val("shr2_acc", 32'(acc_ops), 32'hA000);

        // Left shift by 7, then underflow flush.
        send_op(17'h00100, 17'h00000, 2'b00, 4'd10, 1'b0);
        check_val("shl_acc", 32'(acc_ops), 32'h1800);
        send_op(17'h00100, 17'h00000, 2'b00, 4'd3, 1'b0);
        check_val("flush_acc", 32'(acc_ops), 32'h0000);

        // Clear blocks accept in the same cycle and zeroes count.
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        #1;
        check_val("clr_noready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("clr_idle", 32'(in_ready), 32'd1);
        check_val("clr_count", 32'(out_count), 32'd0);

        // Overflow on the last op of a one-op run.
        send_op(17'h08000, 17'h08000, 2'b00, 4'd15, 1'b1);
        check_val("ovf_valid", 32'(out_valid), 32'd1);
        check_val("ovf_data", 32'(out_data), 32'h7FFF);
        check_val("ovf_sat", 32'(out_sat), 32'd1);
        check_val("ovf_count", 32'(out_count), 32'd1);
        check_val("ovf_acc", 32'(acc_ops), 32'h7FFF);
        handshake();
        check_val("ovf_hs_valid", 32'(out_valid), 32'd0);
        check_val("ovf_hs_sat", 32'(out_sat), 32'd0);
        check_val("ovf_hs_acc", 32'(acc_ops), 32'h0000);

        // Backpressure on a two-op run.
        send_op(17'h08000, 17'h08000, 2'b00, 4'd3, 1'b0);
        send_op(17'h08018, 17'h00000, 2'b00, 4'd5, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_data", 32'(out_data), 32'h2802);
            check_val("bp_ready", 32'(in_ready), 32'd0);
            check_val("bp_count", 32'(out_count), 32'd2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("bp_sat", 32'(out_sat), 32'd0);
        handshake();
        check_val("bp_hs_valid", 32'(out_valid), 32'd0);
        check_val("bp_hs_acc", 32'(acc_ops), 32'h0000);
        check_val("bp_hs_count", 32'(out_count), 32'd0);
        check_val("bp_hs_ready", 32'(in_ready), 32'd1);

        // Clear while the last op sits in ADD drops it.
        send_op(17'h08000, 17'h08000, 2'b00, 4'd3, 1'b0);
        @(negedge clk);
        in_valid   = 1'b1;
        in_last    = 1'b1;
        align_man0 = 17'h08000;
        align_man1 = 17'h00000;
        align_exp  = 4'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("abort_valid", 32'(out_valid), 32'd0);
            check_val("abort_acc", 32'(acc_ops), 32'h0000);
        end
        check_val("abort_ready", 32'(in_ready), 32'd1);
        check_val("abort_count", 32'(out_count), 32'd0);

        // Reset while a result is waiting also zeroes out_data.
        send_op(17'h08000, 17'h00000, 2'b01, 4'd9, 1'b1);
        check_val("pre_rst_data", 32'(out_data), 32'hC800);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mid_rst_data", 32'(out_data), 32'h0000);
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
